// File: rtl/svf_mc.sv
// svf_mc: time-multiplexed multi-channel Chamberlin state-variable filter.
// Define SVF_MC_MIX_EN to add mix_mask/mix_out (masked sum of channel outputs).
module svf_mc #(
   parameter int DATA_W = 8,
   parameter int FRAC_W = 2,
   parameter int NCH    = 3,
   parameter int F_BITS = 5,
   parameter int Q_BITS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NCH*DATA_W-1:0]  in_data,
   input  logic [NCH*F_BITS-1:0]  alpha1,
   input  logic [NCH*Q_BITS-1:0]  alpha2,
   input  logic [NCH*2-1:0]       mode,
   input  logic                   state_clr,
   output logic                   out_valid,
   output logic [NCH*DATA_W-1:0]  out_data
`ifdef SVF_MC_MIX_EN
   ,
   input  logic [NCH-1:0]         mix_mask,
   output logic [DATA_W+1:0]      mix_out
`endif
);

   localparam int W  = DATA_W + FRAC_W;
   localparam int A  = W + 2;
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HP   = 3'd1;
   localparam logic [2:0] S_BP   = 3'd2;
   localparam logic [2:0] S_LP   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]               state_q;
   logic [CW-1:0]            ch_q;
   logic                     clr_pend_q;
   logic signed [W-1:0]      hp_q;
   logic signed [W-1:0]      bp_q   [NCH];
   logic signed [W-1:0]      lp_q   [NCH];
   logic signed [DATA_W-1:0] in_q   [NCH];
   logic [F_BITS-1:0]        a1_q   [NCH];
   logic [Q_BITS-1:0]        a2_q   [NCH];
   logic [1:0]               mode_q [NCH];
   logic [DATA_W-1:0]        out_q  [NCH];

   function automatic logic signed [A-1:0] ext(input logic signed [W-1:0] v);
      return {{2{v[W-1]}}, v};
   endfunction

   function automatic logic signed [W-1:0] sat(input logic signed [A-1:0] v);
      if (v > $signed({3'b000, {(W-1){1'b1}}}))      return {1'b0, {(W-1){1'b1}}};
      else if (v < $signed({3'b111, {(W-1){1'b0}}})) return {1'b1, {(W-1){1'b0}}};
      else                                           return v[W-1:0];
   endfunction

   function automatic logic signed [A-1:0] f_mul(input logic signed [W-1:0] v,
                                                 input logic [F_BITS-1:0]   a);
      logic signed [A-1:0] e, acc;
      e   = ext(v);
      acc = '0;
      for (int i = 0; i < F_BITS; i++) if (a[F_BITS-1-i]) acc = acc + (e >>> (i + 1));
      return acc;
   endfunction

   function automatic logic signed [A-1:0] q_mul(input logic signed [W-1:0] v,
                                                 input logic [Q_BITS-1:0]   a);
      logic signed [A-1:0] e, acc;
      e   = ext(v);
      acc = '0;
      for (int i = 0; i < Q_BITS; i++) if (a[Q_BITS-1-i]) acc = acc + (e >>> i);
      return acc;
   endfunction

   logic signed [W-1:0] bp_cur, lp_cur, hp_new, bp_new, lp_new, notch, sel;
   logic signed [A-1:0] in_ext;
   logic                last_ch, clr_now;

   // In the LP state bp_q already holds bp_new for the current channel.
   always_comb begin
      bp_cur  = bp_q[ch_q];
      lp_cur  = lp_q[ch_q];
      in_ext  = {{2{in_q[ch_q][DATA_W-1]}}, in_q[ch_q], {FRAC_W{1'b0}}};
      hp_new  = sat(in_ext - ext(lp_cur) - q_mul(bp_cur, a2_q[ch_q]));
      bp_new  = sat(ext(bp_cur) + f_mul(hp_q, a1_q[ch_q]));
      lp_new  = sat(ext(lp_cur) + f_mul(bp_cur, a1_q[ch_q]));
      notch   = sat(ext(hp_q) + ext(lp_new));
      case (mode_q[ch_q])
         2'b00:   sel = lp_new;
         2'b01:   sel = bp_cur;
         2'b10:   sel = hp_q;
         default: sel = notch;
      endcase
      last_ch = (ch_q == CW'(NCH - 1));
   end

   assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
   assign out_valid = (state_q == S_DONE);
   assign clr_now   = in_ready && (state_clr || clr_pend_q);

   always_comb begin
      out_data = '0;
      for (int c = 0; c < NCH; c++) out_data[c*DATA_W +: DATA_W] = out_q[c];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ch_q       <= '0;
         clr_pend_q <= 1'b0;
         hp_q       <= '0;
         for (int c = 0; c < NCH; c++) begin
            bp_q[c]   <= '0;
            lp_q[c]   <= '0;
            in_q[c]   <= '0;
            a1_q[c]   <= '0;
            a2_q[c]   <= '0;
            mode_q[c] <= '0;
            out_q[c]  <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               clr_pend_q <= 1'b0;
               if (clr_now) begin
                  for (int c = 0; c < NCH; c++) begin
                     bp_q[c] <= '0;
                     lp_q[c] <= '0;
                  end
               end
               if (in_valid) begin
                  for (int c = 0; c < NCH; c++) begin
                     in_q[c]   <= in_data[c*DATA_W +: DATA_W];
                     a1_q[c]   <= alpha1[c*F_BITS +: F_BITS];
                     a2_q[c]   <= alpha2[c*Q_BITS +: Q_BITS];
                     mode_q[c] <= mode[c*2 +: 2];
                  end
                  ch_q    <= '0;
                  state_q <= S_HP;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_HP: begin
               hp_q    <= hp_new;
               state_q <= S_BP;
            end
            S_BP: begin
               bp_q[ch_q] <= bp_new;
               state_q    <= S_LP;
            end
            S_LP: begin
               lp_q[ch_q]  <= lp_new;
               out_q[ch_q] <= sel[W-1:FRAC_W];
               if (last_ch) begin
                  state_q <= S_DONE;
               end else begin
                  ch_q    <= ch_q + CW'(1);
                  state_q <= S_HP;
               end
            end
            default: state_q <= S_IDLE;
         endcase
         // A clear seen mid-frame is held until the frame completes.
         if (!in_ready && state_clr) clr_pend_q <= 1'b1;
      end
   end

`ifdef SVF_MC_MIX_EN
   logic [DATA_W+1:0] mix_sum;

   always_comb begin
      mix_sum = '0;
      for (int c = 0; c < NCH; c++) begin
         if (mix_mask[c]) begin
            if (CW'(c) == ch_q)
               mix_sum = mix_sum + {{2{sel[W-1]}}, sel[W-1:FRAC_W]};
            else
               mix_sum = mix_sum + {{2{out_q[c][DATA_W-1]}}, out_q[c]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          mix_out <= '0;
      else if (state_q == S_LP && last_ch) mix_out <= mix_sum;
   end
`endif

endmodule

// File: tb/tb_svf_mc.sv
// Randomized self-checking bench for svf_mc against a frame-level behavioural model.
module tb_svf_mc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        state_clr = 1'b0;
   logic        in_ready, out_valid;
   logic [23:0] in_data = '0;
   logic [14:0] alpha1 = '0;
   logic [11:0] alpha2 = '0;
   logic [5:0]  mode = '0;
   logic [23:0] out_data;
`ifdef SVF_MC_MIX_EN
   logic [2:0]  mix_mask = '0;
   logic [9:0]  mix_out;
`endif

   svf_mc dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .alpha1    (alpha1),
      .alpha2    (alpha2),
      .mode      (mode),
      .state_clr (state_clr),
      .out_valid (out_valid),
      .out_data  (out_data)
`ifdef SVF_MC_MIX_EN
      ,
      .mix_mask  (mix_mask),
      .mix_out   (mix_out)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int s_in[3], s_a1[3], s_a2[3], s_mode[3];
   int bp_m[3], lp_m[3], exp_out[3], got[3];

   task automatic check(input string tag, input int got_v, input int exp_v);
      total++;
      if (got_v !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
      end
   endtask

   function automatic int sat(input int v);
      if (v > 511)  return 511;
      if (v < -512) return -512;
      return v;
   endfunction

   // f = alpha1/32 and q = alpha2/8, realised as truncating arithmetic shifts.
   function automatic int fmul(input int v, input int a);
      int acc = 0;
      for (int i = 0; i < 5; i++) if (a[4-i]) acc += v >>> (i + 1);
      return acc;
   endfunction

   function automatic int qmul(input int v, input int a);
      int acc = 0;
      for (int i = 0; i < 4; i++) if (a[3-i]) acc += v >>> i;
      return acc;
   endfunction

   task automatic model_zero();
      for (int c = 0; c < 3; c++) begin
         bp_m[c] = 0;
         lp_m[c] = 0;
      end
   endtask

   task automatic model_frame();
      for (int c = 0; c < 3; c++) begin
         int hp, sel;
         hp      = sat(s_in[c] * 4 - lp_m[c] - qmul(bp_m[c], s_a2[c]));
         bp_m[c] = sat(bp_m[c] + fmul(hp, s_a1[c]));
         lp_m[c] = sat(lp_m[c] + fmul(bp_m[c], s_a1[c]));
         case (s_mode[c])
            0:       sel = lp_m[c];
            1:       sel = bp_m[c];
            2:       sel = hp;
            default: sel = sat(hp + lp_m[c]);
         endcase
         exp_out[c] = sel >>> 2;
      end
   endtask

   task automatic drive_fields();
      for (int c = 0; c < 3; c++) begin
         in_data[c*8 +: 8] = s_in[c][7:0];
         alpha1[c*5 +: 5]  = s_a1[c][4:0];
         alpha2[c*4 +: 4]  = s_a2[c][3:0];
         mode[c*2 +: 2]    = s_mode[c][1:0];
      end
   endtask

   task automatic set_all(input int vin, input int a1, input int a2, input int md);
      for (int c = 0; c < 3; c++) begin
         s_in[c]   = vin;
         s_a1[c]   = a1;
         s_a2[c]   = a2;
         s_mode[c] = md;
      end
   endtask

   task automatic randomize_fields();
      for (int c = 0; c < 3; c++) begin
         s_in[c]   = int'($urandom_range(0, 255)) - 128;
         s_a1[c]   = int'($urandom_range(0, 31));
         s_a2[c]   = int'($urandom_range(0, 15));
         s_mode[c] = int'($urandom_range(0, 3));
      end
   endtask

   task automatic read_out();
      for (int c = 0; c < 3; c++) got[c] = int'($signed(out_data[c*8 +: 8]));
   endtask

   // One frame: accept, scramble inputs, wait for out_valid, compare with model.
   task automatic run_frame(input bit clr, input bit mid_clr, input string tag);
      int n;
      @(negedge clk);
      check({tag, "_ready"}, int'(in_ready), 1);
      drive_fields();
      in_valid  = 1'b1;
      state_clr = clr;
`ifdef SVF_MC_MIX_EN
      mix_mask = 3'($urandom);
`endif
      @(posedge clk);
      if (clr) model_zero();
      model_frame();
      @(negedge clk);
      in_valid  = 1'b0;
      state_clr = 1'b0;
      in_data   = 24'($urandom);
      alpha1    = 15'($urandom);
      alpha2    = 12'($urandom);
      mode      = 6'($urandom);
      n = 1;
      check({tag, "_busy"}, int'(in_ready), 0);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
         state_clr = (mid_clr && n == 4);
      end
      state_clr = 1'b0;
      check({tag, "_latency"}, n, 10);
      read_out();
      for (int c = 0; c < 3; c++) check($sformatf("%s_out%0d", tag, c), got[c], exp_out[c]);
`ifdef SVF_MC_MIX_EN
      begin
         int mx = 0;
         for (int c = 0; c < 3; c++) if (mix_mask[c]) mx += exp_out[c];
         check({tag, "_mix"}, int'($signed(mix_out)), mx);
      end
`endif
      if (mid_clr) model_zero();
   endtask

   initial begin
      int n_rdy, n_busy, n_ov, peak;
      repeat (2) @(negedge clk);
      check("rst_ready", int'(in_ready), 1);
      check("rst_valid", int'(out_valid), 0);
      check("rst_data", int'(out_data), 0);
      rst = 1'b0;
      model_zero();

      // Single-frame response, one mode at a time, each from zero state.
      set_all(0, 16, 8, 0);
      s_in[0] = 64;
      run_frame(1'b1, 1'b0, "lp");
      check("lp_val", got[0], 16);
      s_mode[0] = 1;
      run_frame(1'b1, 1'b0, "bp");
      check("bp_val", got[0], 32);
      s_mode[0] = 2;
      run_frame(1'b1, 1'b0, "hp");
      check("hp_val", got[0], 64);

      // Clear during a frame takes effect only after that frame.
      s_mode[0] = 0;
      run_frame(1'b1, 1'b0, "pre");
      run_frame(1'b0, 1'b1, "midclr");
      run_frame(1'b0, 1'b0, "postclr");
      check("postclr_val", got[0], 16);

      // alpha1 = 0 freezes state; HP passes the input straight through.
      set_all(-100, 0, 5, 2);
      run_frame(1'b1, 1'b0, "a0_f1");
      check("a0_hp1", got[0], -100);
      run_frame(1'b0, 1'b0, "a0_f2");
      check("a0_hp2", got[0], -100);
      set_all(-100, 0, 5, 0);
      run_frame(1'b0, 1'b0, "a0_lp");
      check("a0_lp0", got[0], 0);

      // Large undamped drive: must saturate, never wrap.
      set_all(127, 31, 0, 1);
      peak = -1000;
      for (int f = 0; f < 50; f++) begin
         run_frame(f == 0, 1'b0, "sat");
         if (got[0] > peak) peak = got[0];
      end
      check("sat_peak", peak, 127);

      // Continuous in_valid: one accept every 10 cycles.
      randomize_fields();
      @(negedge clk);
      drive_fields();
      in_valid  = 1'b1;
      state_clr = 1'b1;
      n_rdy = 0; n_busy = 0; n_ov = 0;
      for (int k = 0; k < 50; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) state_clr = 1'b0;
         if (in_ready) n_rdy++; else n_busy++;
         if (out_valid) n_ov++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("cont_ready", n_rdy, 5);
      check("cont_busy", n_busy, 45);
      check("cont_valid", n_ov, 4);
      check("cont_last_valid", int'(out_valid), 1);
      model_zero();
      repeat (5) model_frame();
      read_out();
      for (int c = 0; c < 3; c++) check($sformatf("cont_out%0d", c), got[c], exp_out[c]);

      // Reset during the BP state of channel 0 aborts the frame.
      randomize_fields();
      @(negedge clk);
      drive_fields();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_data", int'(out_data), 0);
      check("arst_valid", int'(out_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      model_zero();
      n_ov = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (out_valid) n_ov++;
      end
      check("arst_no_valid", n_ov, 0);
      check("arst_ready", int'(in_ready), 1);
      set_all(0, 16, 8, 0);
      s_in[0] = 64;
      run_frame(1'b0, 1'b0, "post_rst");
      check("post_rst_val", got[0], 16);

      // Randomized frames with occasional clears.
      for (int f = 0; f < 30; f++) begin
         randomize_fields();
         run_frame($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $sformatf("rnd%0d", f));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
